// File: rtl/rr_arb8_dec_if.sv
// rr_arb8_dec_if: request/grant bundle between the requesters and the round-robin arbiter
//   req      requester -> arbiter, one bit per requester
//   gnt      arbiter -> requester, registered one-hot grant
//   gnt_idx  arbiter -> requester, registered owner index
//   gnt_vld  arbiter -> requester, a grant is active
//   preempt  arbiter -> requester, 1-cycle pulse on a timeout revocation
//   master: requester side, slave: arbiter side
interface rr_arb8_dec_if #(
  parameter int NREQ = 8,
  parameter int IDXW = 3
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [IDXW-1:0] gnt_idx;
  logic            gnt_vld;
  logic            preempt;
  modport master (output req, input gnt, gnt_idx, gnt_vld, preempt);
  modport slave  (input req, output gnt, gnt_idx, gnt_vld, preempt);
endinterface

// File: rtl/rr_arb8_dec.sv
// rr_arb8_dec: 8-way round-robin arbiter with registered grant index and one-hot grant
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  rr_arb8_dec_if.slave: req in, gnt/gnt_idx/gnt_vld/preempt out
//   Optional hold timeout with forced rotation: define RR_ARB_TIMEOUT_EN.
module rr_arb8_dec #(
  parameter int NREQ     = 8,
  parameter int IDXW     = 3,
  parameter int MAX_HOLD = 16
) (
  input logic          clk,
  input logic          rst,
  rr_arb8_dec_if.slave bus
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_OWN  = 1'b1;
  logic [0:0]      r_state;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] w_dec;
  logic [IDXW-1:0] r_idx;
  logic [IDXW-1:0] r_ptr;
  logic [IDXW-1:0] w_base;
  logic [IDXW-1:0] w_pick;
  logic            w_own;
  logic            w_keep;
  logic            w_grant;
  logic            w_rel;
  logic            w_pre;
  assign w_own  = r_state == S_OWN;
  assign w_keep = bus.req[r_idx];
  // While owning, any re-arbitration (release or preemption) scans from the slot after the owner
  assign w_base = w_own ? r_idx + 1'b1 : r_ptr;
  // Scanning downward leaves the lowest rotated offset that is requesting
  always_comb begin
    w_pick = w_base;
    for (int k = NREQ - 1; k >= 0; k--)
      if (bus.req[w_base + IDXW'(k)]) w_pick = w_base + IDXW'(k);
  end
  assign w_dec   = {{(NREQ-1){1'b0}}, 1'b1} << w_pick;
  assign w_grant = ((!w_own || !w_keep) && |bus.req) || w_pre;
  assign w_rel   = w_own && !w_keep && ~|bus.req;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_idx   <= '0;
      r_ptr   <= '0;
    end else if (w_grant) begin
      r_state <= S_OWN;
      r_gnt   <= w_dec;
      r_idx   <= w_pick;
      if (w_own) r_ptr <= r_idx + 1'b1;
    end else if (w_rel) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_ptr   <= r_idx + 1'b1;
    end
`ifdef RR_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] r_cnt;
  logic       r_pre;
  // Revoke only when someone else is waiting; a lone owner keeps the grant with the counter saturated
  assign w_pre = w_own && w_keep && r_cnt == HOLD_LAST && |(bus.req & ~r_gnt);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cnt <= '0;
      r_pre <= 1'b0;
    end else begin
      r_pre <= w_pre;
      r_cnt <= w_grant ? '0 : (w_own && r_cnt != HOLD_LAST) ? r_cnt + 8'd1 : r_cnt;
    end
  assign bus.preempt = r_pre;
`else
  assign w_pre       = 1'b0;
  assign bus.preempt = 1'b0;
`endif
  assign bus.gnt     = r_gnt;
  assign bus.gnt_idx = r_idx;
  assign bus.gnt_vld = w_own;
endmodule

// File: tb/tb_rr_arb8_dec.sv
// tb_rr_arb8_dec: directed and random checks of rr_arb8_dec against a behavioural round-robin model
module tb_rr_arb8_dec;
  localparam int MAX_HOLD = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  int m_own = -1;
  int m_last = 0;
  int m_ptr = 0;
  int m_cnt = 0;
  bit m_pre = 1'b0;
  logic [7:0] r;
  logic [7:0] prev;
  rr_arb8_dec_if bus ();
  rr_arb8_dec #(.MAX_HOLD(MAX_HOLD)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic int pick(logic [7:0] v, int p);
    for (int k = 0; k < 8; k++) if (v[(p + k) % 8]) return (p + k) % 8;
    return -1;
  endfunction
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(logic [7:0] v);
    m_pre = 1'b0;
    if (m_own < 0) begin
      if (v != 0) begin
        m_own = pick(v, m_ptr);
        m_cnt = 0;
      end
    end else if (!v[m_own]) begin
      m_ptr = (m_own + 1) % 8;
      m_own = pick(v, m_ptr);
      m_cnt = 0;
    end
`ifdef RR_ARB_TIMEOUT_EN
    else if (m_cnt == MAX_HOLD - 1 && (v & ~(8'd1 << m_own)) != 0) begin
      m_ptr = (m_own + 1) % 8;
      m_own = pick(v, m_ptr);
      m_cnt = 0;
      m_pre = 1'b1;
    end else if (m_cnt < MAX_HOLD - 1) m_cnt++;
`endif
    if (m_own >= 0) m_last = m_own;
  endtask
  task automatic check_all();
    logic [7:0] eg;
    eg = (m_own >= 0) ? 8'(1 << m_own) : 8'h00;
    chk("gnt", bus.gnt, eg);
    chk("gnt_idx", bus.gnt_idx, m_last);
    chk("gnt_vld", bus.gnt_vld, m_own >= 0);
    chk("preempt", bus.preempt, m_pre);
    chk("gnt_decode", bus.gnt, bus.gnt_vld ? 32'(8'd1 << bus.gnt_idx) : 32'd0);
    chk("onehot0", $onehot0(bus.gnt), 1);
  endtask
  task automatic cycle(logic [7:0] v);
    bus.req = v;
    @(posedge clk);
    if (!rst) step(v);
    @(negedge clk);
    check_all();
  endtask
  task automatic async_reset();
    rst = 1'b1;
    #1;
    m_own = -1;
    m_last = 0;
    m_ptr = 0;
    m_cnt = 0;
    m_pre = 1'b0;
    check_all();
    chk("reset gnt", bus.gnt, 8'h00);
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    bus.req = '0;
    repeat (2) @(negedge clk);
    check_all();
    chk("reset idx", bus.gnt_idx, 0);
    rst = 1'b0;
    cycle(8'h20);
    chk("single gnt", bus.gnt, 8'h20);
    chk("single idx", bus.gnt_idx, 5);
    cycle(8'h00);
    chk("single drop", bus.gnt, 8'h00);
    cycle(8'h09);
    chk("wrap first", bus.gnt_idx, 0);
    cycle(8'h09);
    chk("wrap hold", bus.gnt_idx, 0);
    cycle(8'h08);
    chk("skip second", bus.gnt_idx, 3);
    cycle(8'h00);
    cycle(8'hFF);
    chk("pre-reset owner", bus.gnt_idx, 4);
    async_reset();
    cycle(8'hFF);
    chk("restart gnt", bus.gnt, 8'h01);
    for (int k = 0; k < 9; k++) begin
      cycle(8'hFF & ~(8'd1 << m_own));
      chk("rotate idx", bus.gnt_idx, (k + 1) % 8);
      chk("rotate vld", bus.gnt_vld, 1);
    end
    cycle(8'h00);
    cycle(8'h04);
    chk("hold start", bus.gnt, 8'h04);
    for (int i = 0; i < 40; i++) begin
      cycle(8'h0C);
`ifdef RR_ARB_TIMEOUT_EN
      if (i == 15) begin
        chk("timeout idx", bus.gnt_idx, 3);
        chk("timeout preempt", bus.preempt, 1);
      end
`else
      chk("hold gnt", bus.gnt, 8'h04);
`endif
    end
    cycle(8'h00);
    prev = '0;
    for (int i = 0; i < 600; i++) begin
      if (i == 300) async_reset();
      case ($urandom_range(0, 3))
        0: r = prev;
        1: r = 8'($urandom);
        2: r = 8'($urandom) & 8'($urandom);
        default: r = (m_own >= 0) ? prev | 8'(1 << m_own) : prev;
      endcase
      cycle(r);
      prev = r;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
